instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 169 ++++++++++++++++
 tb/tb_instruction_fetch.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage of a five-stage pipeline.  Holds the fetch program counter
// (pcF), drives the word address into a 64-word instruction memory, and
// captures the returned word into the IF/ID pipeline register for decode.
//
// Ports
//   CLK         single clock, all state changes on the rising edge
//   RESET       asynchronous, active-high reset
//   StallF      hold the PC and the IF/ID register
//   FlushD      load a bubble into the IF/ID register
//   Redirect    load the PC from RedirectPC (taken branch / jump)
//   RedirectPC  redirect target; bits [1:0] are ignored
//   IA          word address to the instruction memory (pcF[7:2])
//   RD          instruction word returned combinationally by the memory
//   InstrD      registered instruction for decode
//   PCPlus4D    registered fetch PC + 4 for decode
//   ValidD      InstrD holds a real fetched instruction
//   Trap        sticky fetch-range fault
//
// Parameter
//   RESET_PC    word-aligned PC value loaded on reset
//
// Configuration macro
//   FETCH_RANGE_TRAP_EN  when defined, fetching from pcF >= 0x100 (beyond the
//                        64-word memory) raises a sticky Trap, loads a bubble
//                        and freezes the stage until reset.  When undefined,
//                        Trap is constant 0 and addresses alias modulo 64 words.
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        StallF,
  input  logic        FlushD,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic [5:0]  IA,
  input  logic [31:0] RD,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        Trap
);

  // Low two bits are forced to zero so a misaligned parameter cannot put the
  // PC on a non-word boundary.
  localparam logic [31:0] ResetPcAligned = RESET_PC & 32'hFFFF_FFFC;

  logic [31:0] pcF;
  logic [31:0] pcPlus4F;
  logic [31:0] pcNext;
  logic [31:0] redirectTarget;
  logic [31:0] instrNext;
  logic [31:0] pcPlus4Next;
  logic        validNext;
  logic        trapped;
  logic        trapNow;

  // Memory address is simply the word index of the PC; above 0x100 the
  // upper bits are dropped, which gives the wrap-around aliasing.
  assign IA             = pcF[7:2];
  assign pcPlus4F       = pcF + 32'd4;
  assign redirectTarget = RedirectPC & 32'hFFFF_FFFC;

`ifdef FETCH_RANGE_TRAP_EN
  localparam logic [31:0] MemLimit = 32'h0000_0100;

  typedef enum logic {
    FETCH_RUN,
    FETCH_TRAPPED
  } fetchState_t;

  fetchState_t state;
  fetchState_t stateNext;

  // Trap state register; only reset can leave the trapped state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= FETCH_RUN;
    end else begin
      state <= stateNext;
    end
  end

  // The trap fires on the first non-stalled edge that would fetch from
  // outside the memory.  trapNow lets that same edge already hold the PC
  // and load a bubble, so the out-of-range word never reaches decode.
  always_comb begin
    stateNext = state;
    trapNow   = 1'b0;
    case (state)
      FETCH_RUN: begin
        if (!StallF && (pcF >= MemLimit)) begin
          trapNow   = 1'b1;
          stateNext = FETCH_TRAPPED;
        end
      end
      FETCH_TRAPPED: begin
        stateNext = FETCH_TRAPPED;
      end
    endcase
  end

  assign trapped = (state == FETCH_TRAPPED);
`else
  assign trapped = 1'b0;
  assign trapNow = 1'b0;
`endif

  assign Trap = trapped;

  // Next-PC selection.  A trap freezes the PC completely; a redirect wins
  // over a stall because the branch outcome must not be lost while decode
  // is held.
  always_comb begin
    pcNext = pcPlus4F;
    if (trapped || trapNow) begin
      pcNext = pcF;
    end else if (Redirect) begin
      pcNext = redirectTarget;
    end else if (StallF) begin
      pcNext = pcF;
    end
  end

  // IF/ID next-value selection.  A flush (or trap) beats a stall so the
  // hazard unit can kill a held instruction.  Redirect by itself does not
  // touch IF/ID; the hazard unit pairs it with FlushD when needed.
  always_comb begin
    instrNext   = InstrD;
    pcPlus4Next = PCPlus4D;
    validNext   = ValidD;
    if (FlushD || trapped || trapNow) begin
      instrNext   = 32'h0000_0000;
      pcPlus4Next = 32'h0000_0000;
      validNext   = 1'b0;
    end else if (!StallF) begin
      instrNext   = RD;
      pcPlus4Next = pcPlus4F;
      validNext   = 1'b1;
    end
  end

  // Fetch PC register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pcF <= ResetPcAligned;
    end else begin
      pcF <= pcNext;
    end
  end

  // IF/ID pipeline register; reset contents are a bubble.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      InstrD   <= 32'h0000_0000;
      PCPlus4D <= 32'h0000_0000;
      ValidD   <= 1'b0;
    end else begin
      InstrD   <= instrNext;
      PCPlus4D <= pcPlus4Next;
      ValidD   <= validNext;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
//
// Self-checking bench for instruction_fetch.  A directed vector table walks
// the reset, stall, redirect/flush, redirect/stall and end-of-memory cases,
// hand-written sequences cover asynchronous reset, and a randomized phase
// compares the DUT against a transaction-level model of the fetch stage.
// Expectations follow FETCH_RANGE_TRAP_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam logic [31:0] ResetPc = 32'h0000_0000;

`ifdef FETCH_RANGE_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  logic        CLK;
  logic        RESET;
  logic        StallF;
  logic        FlushD;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic [5:0]  IA;
  logic [31:0] RD;
  logic [31:0] InstrD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  logic        Trap;

  int checks;
  int errors;

  instruction_fetch #(
    .RESET_PC(ResetPc)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .StallF(StallF),
    .FlushD(FlushD),
    .Redirect(Redirect),
    .RedirectPC(RedirectPC),
    .IA(IA),
    .RD(RD),
    .InstrD(InstrD),
    .PCPlus4D(PCPlus4D),
    .ValidD(ValidD),
    .Trap(Trap)
  );

  // Bench instruction memory: word i holds 0x1000_0000 + i.
  assign RD = 32'h1000_0000 + {26'd0, IA};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] rpc;
    logic [5:0]  expIa;
    logic [31:0] expInstr;
    logic [31:0] expP4;
    logic        expValid;
    logic        expTrap;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: architectural view of the fetch stage.
  logic [31:0] mPc;
  logic [31:0] mInstr;
  logic [31:0] mP4;
  logic        mValid;
  logic        mTrap;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return 32'h1000_0000 + ((addr >> 2) % 64);
  endfunction

  function automatic vec_t mkVec(input logic s, input logic f, input logic r,
                                 input logic [31:0] rpc, input logic [5:0] ia,
                                 input logic [31:0] instr, input logic [31:0] p4,
                                 input logic v, input logic t);
    vec_t x;
    x.stall = s; x.flush = f; x.redirect = r; x.rpc = rpc;
    x.expIa = ia; x.expInstr = instr; x.expP4 = p4; x.expValid = v; x.expTrap = t;
    return x;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAll(input string tag, input logic [5:0] ia, input logic [31:0] instr,
                          input logic [31:0] p4, input logic v, input logic t);
    checkOutput({tag, ".IA"}, {26'd0, IA}, {26'd0, ia});
    checkOutput({tag, ".InstrD"}, InstrD, instr);
    checkOutput({tag, ".PCPlus4D"}, PCPlus4D, p4);
    checkOutput({tag, ".ValidD"}, {31'd0, ValidD}, {31'd0, v});
    checkOutput({tag, ".Trap"}, {31'd0, Trap}, {31'd0, t});
  endtask

  task automatic applyStimulus(input logic s, input logic f, input logic r, input logic [31:0] rpc);
    StallF     = s;
    FlushD     = f;
    Redirect   = r;
    RedirectPC = rpc;
  endtask

  // One rising edge of the fetch stage, described directly from its rules.
  task automatic modelEdge(input logic s, input logic f, input logic r, input logic [31:0] rpc);
    logic [31:0] fetched;
    logic        faultHere;
    fetched   = memWord(mPc);
    faultHere = TrapEn && !s && (mPc >= 32'h100);
    if (mTrap || faultHere) begin
      mTrap  = 1'b1;
      mInstr = 32'h0;
      mP4    = 32'h0;
      mValid = 1'b0;
    end else begin
      if (f) begin
        mInstr = 32'h0; mP4 = 32'h0; mValid = 1'b0;
      end else if (!s) begin
        mInstr = fetched; mP4 = mPc + 32'd4; mValid = 1'b1;
      end
      if (r) mPc = {rpc[31:2], 2'b00};
      else if (!s) mPc = mPc + 32'd4;
    end
  endtask

  task automatic modelReset();
    mPc = ResetPc; mInstr = 32'h0; mP4 = 32'h0; mValid = 1'b0; mTrap = 1'b0;
  endtask

  // Mid-cycle asynchronous reset pulse starting at posedge+1: asserted at
  // posedge+3, checked at posedge+4, released at the falling edge.
  task automatic asyncResetPulse(input string tag);
    #2;
    RESET = 1'b1;
    #1;
    checkAll(tag, ResetPc[7:2], 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    RESET = 1'b0;
  endtask

  initial begin
    logic        s, f, r;
    logic [31:0] rpc;
    checks = 0;
    errors = 0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

    // Reset asserted before any clock edge: values must come straight out.
    RESET = 1'b1;
    #2;
    checkAll("reset", 6'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    RESET = 1'b0;

    // Directed table, starting from PCF = 0.
    vecs.push_back(mkVec(0, 0, 0, 32'h0,  6'd1,  32'h1000_0000, 32'h4,  1, 0));
    vecs.push_back(mkVec(0, 0, 0, 32'h0,  6'd2,  32'h1000_0001, 32'h8,  1, 0));
    vecs.push_back(mkVec(1, 0, 0, 32'h0,  6'd2,  32'h1000_0001, 32'h8,  1, 0));
    vecs.push_back(mkVec(1, 0, 0, 32'h0,  6'd2,  32'h1000_0001, 32'h8,  1, 0));
    vecs.push_back(mkVec(0, 0, 0, 32'h0,  6'd3,  32'h1000_0002, 32'hC,  1, 0));
    vecs.push_back(mkVec(0, 0, 0, 32'h0,  6'd4,  32'h1000_0003, 32'h10, 1, 0));
    vecs.push_back(mkVec(0, 1, 1, 32'h23, 6'd8,  32'h0,         32'h0,  0, 0));
    vecs.push_back(mkVec(0, 0, 0, 32'h0,  6'd9,  32'h1000_0008, 32'h24, 1, 0));
    vecs.push_back(mkVec(1, 0, 1, 32'h40, 6'h10, 32'h1000_0008, 32'h24, 1, 0));
    vecs.push_back(mkVec(0, 0, 0, 32'h0,  6'h11, 32'h1000_0010, 32'h44, 1, 0));
    vecs.push_back(mkVec(0, 0, 1, 32'hFC, 6'h3F, 32'h1000_0011, 32'h48, 1, 0));
    vecs.push_back(mkVec(0, 0, 0, 32'h0,  6'h0,  32'h1000_003F, 32'h100, 1, 0));
`ifdef FETCH_RANGE_TRAP_EN
    vecs.push_back(mkVec(0, 0, 0, 32'h0,  6'h0,  32'h0,         32'h0,  0, 1));
    vecs.push_back(mkVec(0, 0, 1, 32'h10, 6'h0,  32'h0,         32'h0,  0, 1));
    vecs.push_back(mkVec(1, 1, 1, 32'h20, 6'h0,  32'h0,         32'h0,  0, 1));
`else
    vecs.push_back(mkVec(0, 0, 0, 32'h0,  6'h1,  32'h1000_0000, 32'h104, 1, 0));
    vecs.push_back(mkVec(0, 0, 1, 32'h10, 6'h4,  32'h1000_0001, 32'h108, 1, 0));
    vecs.push_back(mkVec(0, 0, 0, 32'h0,  6'h5,  32'h1000_0004, 32'h14,  1, 0));
`endif

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].stall, vecs[i].flush, vecs[i].redirect, vecs[i].rpc);
      @(posedge CLK);
      #1;
      checkAll($sformatf("vec%0d", i), vecs[i].expIa, vecs[i].expInstr,
               vecs[i].expP4, vecs[i].expValid, vecs[i].expTrap);
    end

    // Async reset between edges with a redirect pending on the inputs: the
    // redirect must be discarded and the first free edge fetch RESET_PC.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h80);
    asyncResetPulse("midReset");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge CLK);
    #1;
    checkAll("postReset", 6'd1, 32'h1000_0000, 32'h4, 1'b1, 1'b0);

    // Randomized phase against the reference model.
    modelReset();
    modelEdge(1'b0, 1'b0, 1'b0, 32'h0);
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ((cyc % 45) == 44) begin
        asyncResetPulse($sformatf("rndReset%0d", cyc));
        modelReset();
      end
      s   = ($urandom_range(0, 3) == 0);
      f   = ($urandom_range(0, 6) == 0);
      r   = ($urandom_range(0, 4) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? $urandom() : $urandom_range(0, 32'h11F);
      applyStimulus(s, f, r, rpc);
      @(posedge CLK);
      modelEdge(s, f, r, rpc);
      #1;
      checkAll($sformatf("rnd%0d", cyc), mPc[7:2], mInstr, mP4, mValid, mTrap);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
